// File: rtl/lcb_pkg.sv
// Constants and state encoding shared by the LCB frame packer and receiver.
package lcb_pkg;

    localparam int LCB_FRAME_BYTES    = 15;
    localparam int LCB_GROUPS         = 3;
    localparam int LCB_MEAS_PER_GROUP = 4;
    localparam int LCB_MEAS_PER_FRAME = 12;
    localparam int LCB_ORB_WORDS      = 384;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAITRD = 3'd2,
        ST_SEND   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } lcb_pack_state_t;

    // First orbit-word address of frame n: n*12 built from two shifts.
    function automatic logic [8:0] lcb_frame_base(input logic [4:0] n);
        return {1'b0, n, 3'b000} + {2'b00, n, 2'b00};
    endfunction

endpackage

// File: rtl/lcb_group_fmt.sv
// Selects one byte of a 5-byte LCB group: the packed MSB byte first,
// then the low bytes of the four measures.
module lcb_group_fmt (
    input  logic [9:0] m0,
    input  logic [9:0] m1,
    input  logic [9:0] m2,
    input  logic [9:0] m3,
    input  logic [2:0] byte_sel,
    output logic [7:0] fmt_byte
);

    // Byte mux; out-of-range selections return zero.
    always_comb begin
        fmt_byte = 8'h00;
        case (byte_sel)
            3'd0:    fmt_byte = {m0[9:8], m1[9:8], m2[9:8], m3[9:8]};
            3'd1:    fmt_byte = m0[7:0];
            3'd2:    fmt_byte = m1[7:0];
            3'd3:    fmt_byte = m2[7:0];
            3'd4:    fmt_byte = m3[7:0];
            default: fmt_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcb_frame_packer.sv
// Reads the 12 measures of one LCB frame from orbit-word memory, group by
// group, and streams the 15 packed bytes to a byte-serial transmitter.
module lcb_frame_packer
    import lcb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] frameNum,
    output logic [8:0] measAddr,
    output logic       measRdEn,
    input  logic [11:0] measData,
    output logic [7:0] txData,
    output logic       txStart,
    input  logic       txBusy,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [1:0] K_LAST   = 2'(LCB_MEAS_PER_GROUP - 1);
    localparam logic [1:0] G_LAST   = 2'(LCB_GROUPS - 1);
    localparam logic [2:0] B_LAST   = 3'(LCB_MEAS_PER_GROUP);

    lcb_pack_state_t state_reg, state_next;
    logic [8:0] base_reg, base_next;
    logic [1:0] g_reg, g_next;
    logic [1:0] k_reg, k_next;
    logic [2:0] b_reg, b_next;
    logic [1:0] lat_cnt_reg, lat_cnt_next;
    // Set once the current byte has been handed to the transmitter.
    logic       sent_reg, sent_next;

    logic       cap_en;
    logic       try_send;
    logic       emit;
    logic [8:0] rd_addr;
    logic [7:0] fmt_byte;
    logic [9:0] meas_word;
    logic [9:0] m3_fmt;
    logic [9:0] m_reg [LCB_MEAS_PER_GROUP];
    logic [LCB_MEAS_PER_GROUP-1:0] cap_sel;
    logic       meas_pad_unused;

    // Stored word is {pad, meas, pad}; the pad bits carry nothing.
    assign meas_word       = measData[10:1];
    assign meas_pad_unused = measData[11] ^ measData[0];

    // Address of the next read: base + 4g + k, which is base + {g, k}.
    assign rd_addr = base_next + {5'b00000, g_next, k_next};

    // One capture enable per measure register of the current group.
    for (genvar gi = 0; gi < LCB_MEAS_PER_GROUP; gi++) begin : g_cap_sel
        assign cap_sel[gi] = cap_en && (k_reg == 2'(gi));
    end

    // The MSB byte goes out on the same edge that captures measure 3, so
    // the formatter sees the incoming word instead of the stale register.
    assign m3_fmt = cap_sel[LCB_MEAS_PER_GROUP-1] ? meas_word : m_reg[3];

    lcb_group_fmt u_fmt (
        .m0       (m_reg[0]),
        .m1       (m_reg[1]),
        .m2       (m_reg[2]),
        .m3       (m3_fmt),
        .byte_sel (b_next),
        .fmt_byte (fmt_byte)
    );

    // Next-state logic: read 4 measures, send 5 bytes, repeat per group.
    always_comb begin
        state_next   = state_reg;
        base_next    = base_reg;
        g_next       = g_reg;
        k_next       = k_reg;
        b_next       = b_reg;
        lat_cnt_next = lat_cnt_reg;
        sent_next    = sent_reg;
        cap_en       = 1'b0;
        try_send     = 1'b0;
        emit         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    base_next  = lcb_frame_base(frameNum);
                    g_next     = 2'd0;
                    k_next     = 2'd0;
                    b_next     = 3'd0;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                lat_cnt_next = 2'd0;
                state_next   = ST_WAITRD;
            end
            ST_WAITRD: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    cap_en = 1'b1;
                    if (k_reg != K_LAST) begin
                        k_next     = k_reg + 2'd1;
                        state_next = ST_READ;
                    end else begin
                        b_next     = 3'd0;
                        state_next = ST_SEND;
                        try_send   = 1'b1;
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg + 2'd1;
                end
            end
            ST_SEND: begin
                if (sent_reg) begin
                    state_next = ST_GAP;
                end else begin
                    try_send = 1'b1;
                end
            end
            ST_GAP: begin
                if (b_reg != B_LAST) begin
                    b_next     = b_reg + 3'd1;
                    state_next = ST_SEND;
                    try_send   = 1'b1;
                end else if (g_reg != G_LAST) begin
                    g_next     = g_reg + 2'd1;
                    k_next     = 2'd0;
                    state_next = ST_READ;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // A byte is launched on the edge that enters (or waits in) SEND
        // while the transmitter is free, so txStart is high in SEND itself.
        if (try_send) begin
            emit      = !txBusy;
            sent_next = !txBusy;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            base_reg    <= 9'd0;
            g_reg       <= 2'd0;
            k_reg       <= 2'd0;
            b_reg       <= 3'd0;
            lat_cnt_reg <= 2'd0;
            sent_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            base_reg    <= base_next;
            g_reg       <= g_next;
            k_reg       <= k_next;
            b_reg       <= b_next;
            lat_cnt_reg <= lat_cnt_next;
            sent_reg    <= sent_next;
        end
    end

    // Measure registers of the current group, loaded as read data arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LCB_MEAS_PER_GROUP; i++) begin
                m_reg[i] <= 10'd0;
            end
        end else begin
            for (int i = 0; i < LCB_MEAS_PER_GROUP; i++) begin
                if (cap_sel[i]) begin
                    m_reg[i] <= meas_word;
                end
            end
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            measAddr <= 9'd0;
            measRdEn <= 1'b0;
            txData   <= 8'h00;
            txStart  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            measRdEn <= (state_next == ST_READ);
            if (state_next == ST_READ) begin
                measAddr <= rd_addr;
            end
            txStart <= emit;
            if (emit) begin
                txData <= fmt_byte;
            end
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
        end
    end

endmodule
